// File: rtl/alu_seq.sv
// Sequential 16-bit ALU built from two passes through an external 8-bit combinational ALU.
// Define ALU_SEQ_SUB_EN to enable CMD 6 (SUB16); otherwise CMD 6 reports ERR like CMD 7.
module alu_seq #(
  parameter logic [4:0] OP_ADD       = 5'd0,
  parameter logic [4:0] OP_LOGIC_XOR = 5'd1,
  parameter logic [4:0] OP_LOGIC_OR  = 5'd2,
  parameter logic [4:0] OP_LOGIC_AND = 5'd3,
  parameter logic [4:0] OP_SHL       = 5'd4,
  parameter logic [4:0] OP_SHR       = 5'd5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  cmd_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [4:0]  alu_op_o,
  output logic        alu_sc_in_o,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_sc_out_i,
  output logic [15:0] result_o,
  output logic        carry_o,
  output logic        zero_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_XOR = 3'd1;
  localparam logic [2:0] CMD_OR  = 3'd2;
  localparam logic [2:0] CMD_AND = 3'd3;
  localparam logic [2:0] CMD_SHL = 3'd4;
  localparam logic [2:0] CMD_SHR = 3'd5;
  localparam logic [2:0] CMD_SUB = 3'd6;

  state_t      state_q;
  logic [15:0] a_q, b_q;
  logic [2:0]  cmd_q;
  logic [3:0]  cnt_q;
  logic        carry_q;
  logic [15:0] result_q;
  logic        err_q;

  logic        cmd_legal;
  logic        is_hi;
  logic [7:0]  a_byte, b_byte, w_byte;

  always_comb begin
    cmd_legal = (cmd_i <= CMD_SHR);
`ifdef ALU_SEQ_SUB_EN
    if (cmd_i == CMD_SUB) cmd_legal = 1'b1;
`endif
  end

  // Operand byte selection: LO pass works on bits [7:0], HI pass on [15:8].
  assign is_hi  = (state_q == S_HI);
  assign a_byte = is_hi ? a_q[15:8]      : a_q[7:0];
  assign b_byte = is_hi ? b_q[15:8]      : b_q[7:0];
  assign w_byte = is_hi ? result_q[15:8] : result_q[7:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    alu_a_o     = 8'd0;
    alu_b_o     = 8'd0;
    alu_op_o    = OP_ADD;
    alu_sc_in_o = 1'b0;
    if (state_q == S_LO || state_q == S_HI) begin
      unique case (cmd_q)
        CMD_ADD: begin
          alu_a_o     = a_byte;
          alu_b_o     = b_byte;
          alu_sc_in_o = is_hi ? carry_q : 1'b0;
        end
`ifdef ALU_SEQ_SUB_EN
        CMD_SUB: begin
          alu_a_o     = a_byte;
          alu_b_o     = ~b_byte;
          alu_sc_in_o = is_hi ? carry_q : 1'b1;
        end
`endif
        CMD_XOR, CMD_OR, CMD_AND: begin
          alu_a_o     = a_byte;
          alu_b_o     = b_byte;
          alu_sc_in_o = is_hi ? carry_q : 1'b0;
          alu_op_o    = (cmd_q == CMD_XOR) ? OP_LOGIC_XOR :
                        (cmd_q == CMD_OR)  ? OP_LOGIC_OR  : OP_LOGIC_AND;
        end
        CMD_SHL: begin
          alu_a_o     = w_byte;
          alu_op_o    = OP_SHL;
          alu_sc_in_o = is_hi ? carry_q : 1'b0;
        end
        CMD_SHR: begin
          alu_a_o     = w_byte;
          alu_op_o    = OP_SHR;
          alu_sc_in_o = is_hi ? 1'b0 : carry_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      cmd_q    <= 3'd0;
      cnt_q    <= 4'd0;
      carry_q  <= 1'b0;
      result_q <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cmd_q   <= cmd_i;
            carry_q <= 1'b0;
            if (!cmd_legal) begin
              err_q    <= 1'b1;
              result_q <= 16'd0;
              state_q  <= S_DONE;
            end else begin
              a_q   <= a_i;
              b_q   <= b_i;
              cnt_q <= b_i[3:0];
              if (cmd_i == CMD_SHL || cmd_i == CMD_SHR) begin
                // Shifts work in place on the result register, seeded with A.
                result_q <= a_i;
                if (b_i[3:0] == 4'd0)      state_q <= S_DONE;
                else if (cmd_i == CMD_SHR) state_q <= S_HI;
                else                       state_q <= S_LO;
              end else begin
                state_q <= S_LO;
              end
            end
          end
        end
        S_LO: begin
          result_q[7:0] <= alu_out_i;
          carry_q       <= alu_sc_out_i;
          if (cmd_q == CMD_SHR) begin
            cnt_q   <= cnt_q - 4'd1;
            state_q <= (cnt_q == 4'd1) ? S_DONE : S_HI;
          end else begin
            state_q <= S_HI;
          end
        end
        S_HI: begin
          result_q[15:8] <= alu_out_i;
          if (cmd_q == CMD_XOR || cmd_q == CMD_OR || cmd_q == CMD_AND) carry_q <= 1'b0;
          else                                                         carry_q <= alu_sc_out_i;
          if (cmd_q == CMD_SHL) begin
            cnt_q   <= cnt_q - 4'd1;
            state_q <= (cnt_q == 4'd1) ? S_DONE : S_LO;
          end else if (cmd_q == CMD_SHR) begin
            state_q <= S_LO;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = (result_q == 16'd0);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: models the external 8-bit ALU, runs a vector table,
// randomized operations against a 16-bit arithmetic reference, and a reset-abort sequence.
module tb_alu_seq;

`ifdef ALU_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [15:0] a = 16'd0, b = 16'd0;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic        alu_sc_in, alu_sc_out;
  logic [15:0] result;
  logic        carry, zero, busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .cmd_i(cmd), .a_i(a), .b_i(b),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_sc_in_o(alu_sc_in),
    .alu_out_i(alu_out), .alu_sc_out_i(alu_sc_out),
    .result_o(result), .carry_o(carry), .zero_o(zero),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  // External combinational 8-bit ALU.
  always_comb begin
    alu_out    = 8'd0;
    alu_sc_out = 1'b0;
    case (alu_op)
      5'd0: {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_in};
      5'd1: alu_out = alu_a ^ alu_b;
      5'd2: alu_out = alu_a | alu_b;
      5'd3: alu_out = alu_a & alu_b;
      5'd4: {alu_sc_out, alu_out} = {alu_a, alu_sc_in};
      5'd5: {alu_out, alu_sc_out} = {alu_sc_in, alu_a};
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no byte sequencing.
  task automatic ref_model(input logic [2:0] c, input logic [15:0] ra, input logic [15:0] rb,
                           output logic [15:0] r, output logic cy, output logic e, output int lat);
    int n;
    logic [16:0] wide;
    n = int'(rb[3:0]);
    r = 16'd0; cy = 1'b0; e = 1'b0; lat = 3;
    case (c)
      3'd0: begin wide = {1'b0, ra} + {1'b0, rb}; r = wide[15:0]; cy = wide[16]; end
      3'd1: r = ra ^ rb;
      3'd2: r = ra | rb;
      3'd3: r = ra & rb;
      3'd4, 3'd5: begin
        if (n == 0) begin
          r = ra; lat = 1;
        end else begin
          lat = 2 * n + 1;
          if (c == 3'd4) begin r = ra << n; cy = ra[16 - n]; end
          else           begin r = ra >> n; cy = ra[n - 1];  end
        end
      end
      3'd6: begin
        if (SUB_EN) begin
          wide = {1'b0, ra} + {1'b0, ~rb} + 17'd1; r = wide[15:0]; cy = wide[16];
        end else begin
          e = 1'b1; lat = 1;
        end
      end
      default: begin e = 1'b1; lat = 1; end
    endcase
  endtask

  // Counts clock edges after the accept edge until DONE is seen; bounded.
  task automatic wait_done(input bit noise, output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      start = noise && (lat == 1);
      cmd   = 3'($urandom_range(0, 7));
      a     = 16'($urandom);
      b     = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [2:0] c, input logic [15:0] ra,
                       input logic [15:0] rb, input bit noise,
                       input logic [15:0] er, input logic ec, input logic ee, input int elat);
    int lat;
    logic [15:0] held;
    @(negedge clk);
    cmd = c; a = ra; b = rb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(noise, lat);
    check({name, " latency"}, lat, elat);
    check({name, " result"}, result, er);
    check({name, " carry"}, carry, ec);
    check({name, " zero"}, zero, er == 16'd0);
    check({name, " err"}, err, ee);
    held = result;
    @(posedge clk); #1;
    check({name, " done one cycle"}, {busy, done, err}, 3'b000);
    check({name, " result hold"}, result, held);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  c;
    logic [15:0] ra, rb, er;
    logic        ec, ee;
    int          elat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0]  rc;
    logic [15:0] ra, rb, er;
    logic        ec, ee;
    int          elat;

    vecs.push_back('{"add_00ff", 3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 3});
    vecs.push_back('{"add_ffff", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 3});
    vecs.push_back('{"add_5555", 3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 3});
    vecs.push_back('{"xor",      3'd1, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 3});
    vecs.push_back('{"or",       3'd2, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 3});
    vecs.push_back('{"and",      3'd3, 16'hFF0F, 16'h0FF0, 16'h0F00, 1'b0, 1'b0, 3});
    vecs.push_back('{"shl_8001", 3'd4, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 3});
    vecs.push_back('{"shr_0003", 3'd5, 16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0, 5});
    vecs.push_back('{"shl_zero", 3'd4, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1});
    vecs.push_back('{"shl_b_hi", 3'd4, 16'h0001, 16'hFFF3, 16'h0008, 1'b0, 1'b0, 7});
    vecs.push_back('{"shl_15",   3'd4, 16'hFFFF, 16'h000F, 16'h8000, 1'b1, 1'b0, 31});
    vecs.push_back('{"shr_15",   3'd5, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 31});
    vecs.push_back('{"illegal7", 3'd7, 16'h5A5A, 16'h0003, 16'h0000, 1'b0, 1'b1, 1});
    if (SUB_EN)
      vecs.push_back('{"sub",    3'd6, 16'h0100, 16'h0001, 16'h00FF, 1'b1, 1'b0, 3});
    else
      vecs.push_back('{"sub_off",3'd6, 16'h0100, 16'h0001, 16'h0000, 1'b0, 1'b1, 1});

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", {busy, done, err, carry, zero}, 5'b00001);
    check("reset result", result, 16'h0000);
    check("reset alu drive", {alu_a, alu_b, alu_op, alu_sc_in}, 22'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].c, vecs[i].ra, vecs[i].rb, 1'b0,
            vecs[i].er, vecs[i].ec, vecs[i].ee, vecs[i].elat);

    // Randomized operations, with spurious START pulses while busy.
    for (int i = 0; i < 60; i++) begin
      rc = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 == 0) ra = (i % 8 == 0) ? 16'hFFFF : 16'h0000;
      ref_model(rc, ra, rb, er, ec, ee, elat);
      do_op("rand", rc, ra, rb, 1'b1, er, ec, ee, elat);
    end

    // Reset in the HI pass of SHL16 by 8, START held high throughout.
    @(negedge clk);
    cmd = 3'd4; a = 16'h00FF; b = 16'h0008; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort busy before reset", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; cmd = 3'd0; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    check("abort flags", {busy, done, err, carry, zero}, 5'b00001);
    check("abort result", result, 16'h0000);
    check("abort alu drive", {alu_a, alu_b, alu_op, alu_sc_in}, 22'd0);
    @(posedge clk); #1;
    check("abort no done", {busy, done}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    begin
      int lat;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, lat);
      check("post reset latency", lat, 3);
      check("post reset result", result, 16'h0003);
      check("post reset carry", carry, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
